// File: rtl/sram_ctrl_pkg.sv
// Shared widths, state encoding and response record for the SRAM access controller.
// States VSETUP/VCAPT exist only when SRAM_CTRL_WRVERIFY_EN is defined.
package sram_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETUP  = 3'd1;
    localparam state_t ST_STROBE = 3'd2;
    localparam state_t ST_HOLD   = 3'd3;
    localparam state_t ST_CAPT   = 3'd4;
    localparam state_t ST_RESP   = 3'd5;
`ifdef SRAM_CTRL_WRVERIFY_EN
    localparam state_t ST_VSETUP = 3'd6;
    localparam state_t ST_VCAPT  = 3'd7;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

endpackage

// File: rtl/sram_ctrl_timer.sv
// Loadable 4-bit down-counter with a zero flag; it saturates at zero.
module sram_ctrl_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Sequences one request at a time into an asynchronous SRAM strobe/capture cycle.
// Define SRAM_CTRL_WRVERIFY_EN to read back every write and flag mismatches on RspErr.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    // Request/response: a transfer happens on a cycle where valid and ready are both 1;
    // the response is held stable until RspReady is seen with RspValid.
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [DATA_W-1:0] RspData,
    output logic              RspErr,
    output logic [DATA_W-1:0] SramI,
    output logic [ADDR_W-1:0] SramSel,
    output logic              SramRead,
    output logic              SramClear,
    input  logic [DATA_W-1:0] SramO,
    output logic [2:0]        DbgState
);

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sel_q, sel_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              sram_read_q, sram_read_d;
    logic              clear_q;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic [3:0]        tmr_val;
    rsp_t              rsp_out;
`ifdef SRAM_CTRL_WRVERIFY_EN
    logic              rsp_err_q, rsp_err_d;
`endif

    sram_ctrl_timer u_timer (
        .clk      (Clk),
        .rst      (Reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        din_d      = din_q;
        wr_d       = wr_q;
        rsp_data_d = rsp_data_q;
`ifdef SRAM_CTRL_WRVERIFY_EN
        rsp_err_d  = rsp_err_q;
`endif
        tmr_load   = 1'b0;
        tmr_val    = SETUP_LD;
        tmr_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ReqValid) begin
                    state_d  = ST_SETUP;
                    sel_d    = ReqAddr;
                    din_d    = ReqData;
                    wr_d     = ReqWrite;
                    tmr_load = 1'b1;
                end
            end
            ST_SETUP: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (wr_q) begin
                    state_d  = ST_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = STROBE_LD;
                end else begin
                    state_d = ST_CAPT;
                end
            end
            ST_STROBE: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
`ifdef SRAM_CTRL_WRVERIFY_EN
                state_d  = ST_VSETUP;
                tmr_load = 1'b1;
`else
                state_d    = ST_RESP;
                rsp_data_d = din_q;
`endif
            end
            ST_CAPT: begin
                state_d    = ST_RESP;
                rsp_data_d = SramO;
`ifdef SRAM_CTRL_WRVERIFY_EN
                rsp_err_d  = 1'b0;
`endif
            end
`ifdef SRAM_CTRL_WRVERIFY_EN
            ST_VSETUP: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    state_d = ST_VCAPT;
                end
            end
            ST_VCAPT: begin
                state_d    = ST_RESP;
                rsp_data_d = SramO;
                rsp_err_d  = (SramO != din_q);
            end
`endif
            ST_RESP: begin
                if (RspReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered from the next state so the array sees a clean falling edge.
        sram_read_d = (state_d != ST_STROBE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            din_q       <= '0;
            wr_q        <= 1'b0;
            rsp_data_q  <= '0;
            sram_read_q <= 1'b1;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            din_q       <= din_d;
            wr_q        <= wr_d;
            rsp_data_q  <= rsp_data_d;
            sram_read_q <= sram_read_d;
            clear_q     <= 1'b1;
        end
    end

`ifdef SRAM_CTRL_WRVERIFY_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_out = '{data: rsp_data_q, err: rsp_err_q};
`else
    assign rsp_out = '{data: rsp_data_q, err: 1'b0};
`endif

    assign ReqReady  = (state_q == ST_IDLE) && !Reset;
    assign RspValid  = (state_q == ST_RESP);
    assign RspData   = rsp_out.data;
    assign RspErr    = rsp_out.err;
    assign SramI     = din_q;
    assign SramSel   = sel_q;
    assign SramRead  = sram_read_q;
    assign SramClear = clear_q;
    assign DbgState  = state_q;

endmodule
